// File: rtl/contador_pkg.sv
// Shared encodings and default sizes for the contador_eventos debug counter.
// Optional feature macro used by the top level: CONTADOR_SNAPSHOT_EN.
package contador_pkg;

   localparam int unsigned ESTADO_W            = 2;
   localparam int unsigned CONTADOR_LENGTH_DEF = 11;
   localparam int unsigned NB_CANALES_DEF      = 4;
   localparam int unsigned NB_SEL_DEF          = 2;

   typedef enum logic [ESTADO_W-1:0] {
      ESTADO_IDLE   = 2'b00,
      ESTADO_RUN    = 2'b01,
      ESTADO_HALTED = 2'b10
   } estado_t;

endpackage

// File: rtl/contador_canal.sv
// One counter: counts on enable, wraps or saturates at all-ones, sticky overflow flag.
module contador_canal #(
   parameter int unsigned CONTADOR_LENGTH = 11,
   parameter int unsigned SATURAR         = 0
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_clear,
   input  logic                       i_enable,
   output logic [CONTADOR_LENGTH-1:0] o_cuenta,
   output logic                       o_overflow
);

   localparam logic [CONTADOR_LENGTH-1:0] CUENTA_MAX = '1;

   // Count update; reset and clear win over enable so the clearing edge adds nothing.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         o_cuenta   <= '0;
         o_overflow <= 1'b0;
      end else if (i_enable) begin
         if (o_cuenta == CUENTA_MAX) begin
            o_overflow <= 1'b1;
            if (SATURAR == 0) begin
               o_cuenta <= '0;
            end
         end else begin
            o_cuenta <= o_cuenta + CONTADOR_LENGTH'(1);
         end
      end
   end

endmodule

// File: rtl/contador_eventos.sv
// Multi-channel cycle/event counter with idle/run/halted run control.
// Optional snapshot bank enabled with macro CONTADOR_SNAPSHOT_EN.
module contador_eventos
   import contador_pkg::*;
#(
   parameter int unsigned CONTADOR_LENGTH = CONTADOR_LENGTH_DEF,
   parameter int unsigned NB_CANALES      = NB_CANALES_DEF,
   parameter int unsigned NB_SEL          = NB_SEL_DEF,
   parameter int unsigned SATURAR         = 0
) (
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic                       i_stop,
   input  logic                       i_halt,
   input  logic                       i_clear,
   input  logic [NB_CANALES-1:0]      i_evento,
   input  logic                       i_snapshot,
   input  logic [NB_SEL-1:0]          i_sel,
   output logic [CONTADOR_LENGTH-1:0] o_cuenta,
   output logic [CONTADOR_LENGTH-1:0] o_ciclos,
   output logic [NB_CANALES:0]        o_overflow,
   output logic [ESTADO_W-1:0]        o_estado
);

   estado_t                    estado;
   logic                       run;
   logic [CONTADOR_LENGTH-1:0] cuentas [NB_CANALES];
   logic [CONTADOR_LENGTH-1:0] ciclos;
   logic [NB_CANALES:0]        overflow;
   logic [CONTADOR_LENGTH-1:0] lectura_cuentas [NB_CANALES];
   logic [CONTADOR_LENGTH-1:0] lectura_ciclos;

   assign run = (estado == ESTADO_RUN);

   // Run-control state machine; stop beats halt beats start.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         estado <= ESTADO_IDLE;
      end else begin
         case (estado)
            ESTADO_IDLE: begin
               if (i_start) estado <= ESTADO_RUN;
            end
            ESTADO_RUN: begin
               if (i_stop)      estado <= ESTADO_IDLE;
               else if (i_halt) estado <= ESTADO_HALTED;
            end
            ESTADO_HALTED: begin
               if (i_stop) estado <= ESTADO_IDLE;
            end
            default: estado <= ESTADO_IDLE;
         endcase
      end
   end

   // Event channels, gated by the registered RUN state.
   for (genvar g = 0; g < NB_CANALES; g++) begin : g_canal
      contador_canal #(
         .CONTADOR_LENGTH (CONTADOR_LENGTH),
         .SATURAR         (SATURAR)
      ) u_canal (
         .i_clock    (i_clock),
         .i_reset    (i_reset),
         .i_clear    (i_clear),
         .i_enable   (run & i_evento[g]),
         .o_cuenta   (cuentas[g]),
         .o_overflow (overflow[g])
      );
   end

   // Free cycle counter, one count per RUN cycle.
   contador_canal #(
      .CONTADOR_LENGTH (CONTADOR_LENGTH),
      .SATURAR         (SATURAR)
   ) u_ciclos (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_clear    (i_clear),
      .i_enable   (run),
      .o_cuenta   (ciclos),
      .o_overflow (overflow[NB_CANALES])
   );

`ifdef CONTADOR_SNAPSHOT_EN
   logic [CONTADOR_LENGTH-1:0] snap_cuentas [NB_CANALES];
   logic [CONTADOR_LENGTH-1:0] snap_ciclos;

   // Snapshot bank: captures pre-update counter values; clear wins over capture.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         for (int i = 0; i < int'(NB_CANALES); i++) begin
            snap_cuentas[i] <= '0;
         end
         snap_ciclos <= '0;
      end else if (i_snapshot) begin
         for (int i = 0; i < int'(NB_CANALES); i++) begin
            snap_cuentas[i] <= cuentas[i];
         end
         snap_ciclos <= ciclos;
      end
   end

   assign lectura_cuentas = snap_cuentas;
   assign lectura_ciclos  = snap_ciclos;
`else
   assign lectura_cuentas = cuentas;
   assign lectura_ciclos  = ciclos;
`endif

   // Selected-channel readout, one cycle of latency; out-of-range selects read 0.
   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         o_cuenta <= '0;
      end else if (32'(i_sel) < NB_CANALES) begin
         o_cuenta <= lectura_cuentas[i_sel];
      end else begin
         o_cuenta <= '0;
      end
   end

   assign o_ciclos   = lectura_ciclos;
   assign o_overflow = overflow;
   assign o_estado   = estado;

endmodule

// File: tb/tb_contador_eventos.sv
// Directed bench for contador_eventos: run control, events, overflow, priorities, snapshot.
module tb_contador_eventos;

   localparam int unsigned L  = 11;
   localparam int unsigned NC = 4;
   localparam int unsigned NS = 2;

   logic          clk = 1'b0;
   logic          i_reset, i_start, i_stop, i_halt, i_clear, i_snapshot;
   logic [NC-1:0] i_evento;
   logic [NS-1:0] i_sel;

   logic [L-1:0]  o_cuenta, o_ciclos;
   logic [NC:0]   o_overflow;
   logic [1:0]    o_estado;

   logic [3:0]    w_cuenta, w_ciclos, s_cuenta, s_ciclos;
   logic [NC:0]   w_overflow, s_overflow;
   logic [1:0]    w_estado, s_estado;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   contador_eventos #(.CONTADOR_LENGTH(L), .NB_CANALES(NC), .NB_SEL(NS), .SATURAR(0)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop), .i_halt(i_halt),
      .i_clear(i_clear), .i_evento(i_evento), .i_snapshot(i_snapshot), .i_sel(i_sel),
      .o_cuenta(o_cuenta), .o_ciclos(o_ciclos), .o_overflow(o_overflow), .o_estado(o_estado));

   contador_eventos #(.CONTADOR_LENGTH(4), .NB_CANALES(NC), .NB_SEL(NS), .SATURAR(0)) dut_wrap (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop), .i_halt(i_halt),
      .i_clear(i_clear), .i_evento(i_evento), .i_snapshot(i_snapshot), .i_sel(i_sel),
      .o_cuenta(w_cuenta), .o_ciclos(w_ciclos), .o_overflow(w_overflow), .o_estado(w_estado));

   contador_eventos #(.CONTADOR_LENGTH(4), .NB_CANALES(NC), .NB_SEL(NS), .SATURAR(1)) dut_sat (
      .i_clock(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop), .i_halt(i_halt),
      .i_clear(i_clear), .i_evento(i_evento), .i_snapshot(i_snapshot), .i_sel(i_sel),
      .o_cuenta(s_cuenta), .o_ciclos(s_ciclos), .o_overflow(s_overflow), .o_estado(s_estado));

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      i_clear = 1'b1; step(1); i_clear = 1'b0;
   endtask

   // Start sampled at "edge 0".
   task automatic do_start();
      i_start = 1'b1; step(1); i_start = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; step(2); i_reset = 1'b0;
      tests++; if (o_ciclos !== 11'd0) begin errors++; $display("FAIL reset_ciclos got %0d want 0", o_ciclos); end
      tests++; if (o_cuenta !== 11'd0) begin errors++; $display("FAIL reset_cuenta got %0d want 0", o_cuenta); end
      tests++; if (o_overflow !== 5'd0) begin errors++; $display("FAIL reset_overflow got %b want 0", o_overflow); end
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL reset_estado got %b want 00", o_estado); end
   endtask

   task automatic test_ciclos();
      do_clear();
      do_start();
      tests++; if (o_estado !== 2'b01) begin errors++; $display("FAIL ciclos_run got %b want 01", o_estado); end
      tests++; if (o_ciclos !== 11'd0) begin errors++; $display("FAIL ciclos_first got %0d want 0", o_ciclos); end
      step(1);
      tests++; if (o_ciclos !== 11'd1) begin errors++; $display("FAIL ciclos_second got %0d want 1", o_ciclos); end
      step(8);
      i_stop = 1'b1; step(1); i_stop = 1'b0;
      tests++; if (o_ciclos !== 11'd10) begin errors++; $display("FAIL ciclos_stop got %0d want 10", o_ciclos); end
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL ciclos_idle got %b want 00", o_estado); end
      step(5);
      tests++; if (o_ciclos !== 11'd10) begin errors++; $display("FAIL ciclos_hold got %0d want 10", o_ciclos); end
   endtask

   task automatic test_eventos();
      do_clear();
      i_sel = 2'd0;
      do_start();
      for (int k = 1; k <= 8; k++) begin
         i_evento = {1'b0, (k == 2 || k == 4 || k == 7), 1'b0, 1'b1};
         i_stop   = (k == 8);
         step(1);
      end
      i_evento = '0; i_stop = 1'b0;
      tests++; if (o_ciclos !== 11'd8) begin errors++; $display("FAIL eventos_ciclos got %0d want 8", o_ciclos); end
      step(1);
      tests++; if (o_cuenta !== 11'd8) begin errors++; $display("FAIL eventos_ch0 got %0d want 8", o_cuenta); end
      i_sel = 2'd2; step(1);
      tests++; if (o_cuenta !== 11'd3) begin errors++; $display("FAIL eventos_ch2 got %0d want 3", o_cuenta); end
      i_sel = 2'd1; step(1);
      tests++; if (o_cuenta !== 11'd0) begin errors++; $display("FAIL eventos_ch1 got %0d want 0", o_cuenta); end
      i_sel = 2'd0;
   endtask

   task automatic test_overflow();
      do_clear();
      do_start();
      step(16);
      i_stop = 1'b1; step(1); i_stop = 1'b0;
      tests++; if (w_ciclos !== 4'd1) begin errors++; $display("FAIL wrap_ciclos got %0d want 1", w_ciclos); end
      tests++; if (w_overflow[NC] !== 1'b1) begin errors++; $display("FAIL wrap_flag got %b want 1", w_overflow[NC]); end
      tests++; if (s_ciclos !== 4'd15) begin errors++; $display("FAIL sat_ciclos got %0d want 15", s_ciclos); end
      tests++; if (s_overflow[NC] !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", s_overflow[NC]); end
      tests++; if (o_overflow !== 5'd0) begin errors++; $display("FAIL wide_flag got %b want 0", o_overflow); end
      step(3);
      tests++; if (w_overflow[NC] !== 1'b1) begin errors++; $display("FAIL wrap_sticky got %b want 1", w_overflow[NC]); end
      do_clear();
      tests++; if (w_overflow !== 5'd0) begin errors++; $display("FAIL wrap_cleared got %b want 0", w_overflow); end
   endtask

   task automatic test_halt();
      do_clear();
      do_start();
      step(4);
      i_halt = 1'b1; step(1); i_halt = 1'b0;
      tests++; if (o_ciclos !== 11'd5) begin errors++; $display("FAIL halt_ciclos got %0d want 5", o_ciclos); end
      tests++; if (o_estado !== 2'b10) begin errors++; $display("FAIL halt_estado got %b want 10", o_estado); end
      do_start();
      step(2);
      tests++; if (o_estado !== 2'b10) begin errors++; $display("FAIL halt_start_ignored got %b want 10", o_estado); end
      tests++; if (o_ciclos !== 11'd5) begin errors++; $display("FAIL halt_frozen got %0d want 5", o_ciclos); end
      i_stop = 1'b1; step(1); i_stop = 1'b0;
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL halt_stop got %b want 00", o_estado); end
   endtask

   task automatic test_simultaneos();
      // Clear together with start.
      do_clear();
      i_evento = 4'b0001;
      do_start();
      step(3);
      i_clear = 1'b1; i_start = 1'b1; step(1); i_clear = 1'b0; i_start = 1'b0;
      i_evento = '0;
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL clrstart_estado got %b want 00", o_estado); end
      tests++; if (o_ciclos !== 11'd0) begin errors++; $display("FAIL clrstart_ciclos got %0d want 0", o_ciclos); end
      tests++; if (o_cuenta !== 11'd0) begin errors++; $display("FAIL clrstart_cuenta got %0d want 0", o_cuenta); end
      // Stop together with halt while running.
      do_start();
      step(2);
      i_stop = 1'b1; i_halt = 1'b1; step(1); i_stop = 1'b0; i_halt = 1'b0;
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL stophalt_estado got %b want 00", o_estado); end
      tests++; if (o_ciclos !== 11'd3) begin errors++; $display("FAIL stophalt_ciclos got %0d want 3", o_ciclos); end
      // Reset at cycle 3 of a run.
      do_clear();
      i_evento = 4'b0001;
      do_start();
      step(2);
      i_reset = 1'b1; step(1); i_reset = 1'b0;
      i_evento = '0;
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL rstrun_estado got %b want 00", o_estado); end
      tests++; if (o_ciclos !== 11'd0) begin errors++; $display("FAIL rstrun_ciclos got %0d want 0", o_ciclos); end
      tests++; if (o_cuenta !== 11'd0) begin errors++; $display("FAIL rstrun_cuenta got %0d want 0", o_cuenta); end
      tests++; if (o_overflow !== 5'd0) begin errors++; $display("FAIL rstrun_overflow got %b want 0", o_overflow); end
   endtask

   task automatic test_snapshot();
      logic [L-1:0] exp_ciclos;
`ifdef CONTADOR_SNAPSHOT_EN
      exp_ciclos = 11'd12;
`else
      exp_ciclos = 11'd20;
`endif
      do_clear();
      i_sel    = 2'd0;
      i_evento = 4'b0001;
      do_start();
      step(12);
      // Live counter reads 12 here; the capture edge takes that pre-update value.
      i_snapshot = 1'b1; step(1); i_snapshot = 1'b0;
      step(6);
      i_stop = 1'b1; step(1); i_stop = 1'b0;
      i_evento = '0;
      step(1);
      tests++; if (o_ciclos !== exp_ciclos) begin errors++; $display("FAIL snap_ciclos got %0d want %0d", o_ciclos, exp_ciclos); end
      tests++; if (o_cuenta !== exp_ciclos) begin errors++; $display("FAIL snap_cuenta got %0d want %0d", o_cuenta, exp_ciclos); end
      tests++; if (o_estado !== 2'b00) begin errors++; $display("FAIL snap_estado got %b want 00", o_estado); end
   endtask

   initial begin
      i_reset = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_halt = 1'b0;
      i_clear = 1'b0; i_snapshot = 1'b0; i_evento = '0; i_sel = '0;
      #2;
      test_reset();
      test_ciclos();
      test_eventos();
      test_overflow();
      test_halt();
      test_simultaneos();
      test_snapshot();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
